// File: rtl/stream_line_loader.sv
// Streams pixel-pair beats from an upstream source into one half of a double-buffered line buffer.
// Optional macro LOADER_PAD_EN: zero-fill the remainder of a line that ends early.
module stream_line_loader #(
  parameter int address_width = 7,
  parameter int data_width    = 48,
  parameter int line_length   = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [4:0]               y,
  output logic                     is_idle,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [data_width-1:0]    in_data,
  input  logic                     in_last,
  output logic [address_width-1:0] write_address,
  output logic [data_width-1:0]    write_data,
  output logic                     write_enable,
  output logic                     line_error
);

  localparam int x_width = $clog2(line_length);
  localparam logic [x_width-1:0] x_max = x_width'(line_length - 1);

  typedef enum logic [1:0] {kIdle, kLoad, kPad, kFlush} state_t;

  state_t                   state_q, state_d;
  logic [x_width-1:0]       x_q, x_d;
  logic                     y_latched_q, y_latched_d;
  logic                     line_error_q, line_error_d;
  logic                     write_enable_q, write_enable_d;
  logic [address_width-1:0] write_address_q, write_address_d;
  logic [data_width-1:0]    write_data_q, write_data_d;
  logic [address_width-1:0] line_addr;

  // Only the row parity selects the buffer half; the other row bits are not needed here.
  logic unused_y;
  assign unused_y = ^y[4:1];

  always_comb begin
    line_addr = '0;
    line_addr[address_width-1] = y_latched_q;
    line_addr[x_width-1:0]     = x_q;
  end

  always_comb begin
    state_d         = state_q;
    x_d             = x_q;
    y_latched_d     = y_latched_q;
    line_error_d    = line_error_q;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    is_idle         = 1'b0;
    in_ready        = 1'b0;

    case (state_q)
      kIdle: begin
        is_idle = 1'b1;
        if (start) begin
          y_latched_d  = y[0];
          x_d          = '0;
          line_error_d = 1'b0;
          state_d      = kLoad;
        end
      end

      kLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          write_enable_d  = 1'b1;
          write_address_d = line_addr;
          write_data_d    = in_data;
          // x saturates at the last column so the address never wraps within a line.
          if (x_q == x_max) begin
            if (in_last) begin
              state_d = kIdle;
            end else begin
              line_error_d = 1'b1;
              state_d      = kFlush;
            end
          end else begin
            x_d = x_q + x_width'(1);
            if (in_last) begin
              line_error_d = 1'b1;
              state_d      = kPad;
            end
          end
        end
      end

      kPad: begin
`ifdef LOADER_PAD_EN
        write_enable_d  = 1'b1;
        write_address_d = line_addr;
        write_data_d    = '0;
        if (x_q == x_max) begin
          state_d = kIdle;
        end else begin
          x_d = x_q + x_width'(1);
        end
`else
        state_d = kIdle;
`endif
      end

      kFlush: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_d = kIdle;
        end
      end

      default: state_d = kIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= kIdle;
      x_q             <= '0;
      y_latched_q     <= 1'b0;
      line_error_q    <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
    end else begin
      state_q         <= state_d;
      x_q             <= x_d;
      y_latched_q     <= y_latched_d;
      line_error_q    <= line_error_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
    end
  end

  assign write_enable  = write_enable_q;
  assign write_address = write_address_q;
  assign write_data    = write_data_q;
  assign line_error    = line_error_q;

endmodule

// File: tb/tb_stream_line_loader.sv
// Directed bench for stream_line_loader: a table of single-cycle vectors plus multi-cycle line sequences.
// Expected pad behaviour follows the LOADER_PAD_EN macro.
module tb_stream_line_loader;

  localparam int AW = 7;
  localparam int DW = 48;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [4:0]    y;
  logic          is_idle;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          write_enable;
  logic          line_error;

  int checks = 0;
  int errors = 0;

  stream_line_loader #(.address_width(AW), .data_width(DW), .line_length(64)) dut (
    .clock(clock), .reset(reset), .start(start), .y(y), .is_idle(is_idle),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .write_address(write_address), .write_data(write_data),
    .write_enable(write_enable), .line_error(line_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t wq[$];
  wr_t eq[$];

  // Line buffer writes are captured on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (write_enable === 1'b1) wq.push_back('{write_address, write_data});
  end

  typedef struct {
    logic          start;
    logic [4:0]    y;
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
    logic          exp_idle;
    logic          exp_ready;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [4:0] yy, input logic v,
                              input logic [DW-1:0] d, input logic l, input logic ei,
                              input logic er, input logic ew, input logic [AW-1:0] ea,
                              input logic [DW-1:0] ed, input logic ee);
    vec_t r;
    r.start = s; r.y = yy; r.valid = v; r.data = d; r.last = l;
    r.exp_idle = ei; r.exp_ready = er; r.exp_we = ew;
    r.exp_addr = ea; r.exp_data = ed; r.exp_err = ee;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; y = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_is_idle", 64'(is_idle), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_we", 64'(write_enable), 64'd0);
    check("rst_addr", 64'(write_address), 64'd0);
    check("rst_data", 64'(write_data), 64'd0);
    check("rst_err", 64'(line_error), 64'd0);
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic start_line(input logic [4:0] row);
    start = 1'b1; y = row;
    step();
    start = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_write_count"}, 64'(wq.size()), 64'(eq.size()));
    for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
      check($sformatf("%s_addr_%0d", tag, i), 64'(wq[i].a), 64'(eq[i].a));
      check($sformatf("%s_data_%0d", tag, i), 64'(wq[i].d), 64'(eq[i].d));
    end
  endtask

  vec_t vecs[7];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beat;
    int n;
    reset = 1'b1;
    idle_inputs();

    // Vector table: inputs held across one rising edge, outputs checked just after it.
    vecs[0] = mk(0, 0, 0, 48'h0, 0, 1, 0, 0, 7'h00, 48'h0, 0);
    vecs[1] = mk(1, 7, 0, 48'h0, 0, 0, 1, 0, 7'h00, 48'h0, 0);
    vecs[2] = mk(0, 0, 1, 48'hA, 0, 0, 1, 1, 7'h40, 48'hA, 0);
    vecs[3] = mk(0, 0, 0, 48'hB, 0, 0, 1, 0, 7'h00, 48'h0, 0);
    vecs[4] = mk(1, 0, 1, 48'hC, 0, 0, 1, 1, 7'h41, 48'hC, 0);
    vecs[5] = mk(0, 0, 1, 48'hD, 1, 0, 0, 1, 7'h42, 48'hD, 1);
`ifdef LOADER_PAD_EN
    vecs[6] = mk(0, 0, 0, 48'h0, 0, 0, 0, 1, 7'h43, 48'h0, 1);
`else
    vecs[6] = mk(0, 0, 0, 48'h0, 0, 1, 0, 0, 7'h00, 48'h0, 1);
`endif

    apply_reset();

    for (int i = 0; i < 7; i++) begin
      start = vecs[i].start; y = vecs[i].y; in_valid = vecs[i].valid;
      in_data = vecs[i].data; in_last = vecs[i].last;
      step();
      check($sformatf("vec%0d_is_idle", i), 64'(is_idle), 64'(vecs[i].exp_idle));
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ready));
      check($sformatf("vec%0d_we", i), 64'(write_enable), 64'(vecs[i].exp_we));
      check($sformatf("vec%0d_err", i), 64'(line_error), 64'(vecs[i].exp_err));
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d_addr", i), 64'(write_address), 64'(vecs[i].exp_addr));
        check($sformatf("vec%0d_data", i), 64'(write_data), 64'(vecs[i].exp_data));
      end
    end
    idle_inputs();
    apply_reset();

    // Full line, in_valid always high.
    wq.delete(); eq.delete();
    start_line(5'd3);
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1; in_data = DW'(i); in_last = (i == 63);
      eq.push_back('{AW'(7'h40 + i), DW'(i)});
      step();
    end
    check("full_is_idle_after_last", 64'(is_idle), 64'd1);
    check("full_final_we", 64'(write_enable), 64'd1);
    idle_inputs();
    step();
    check("full_err", 64'(line_error), 64'd0);
    compare_writes("full");

    // Full line with in_valid toggling every cycle.
    wq.delete(); eq.delete();
    start_line(5'd4);
    beat = 0;
    for (int c = 0; c < 200 && beat < 64; c++) begin
      in_valid = (c % 2 == 0);
      in_data = DW'(200 + beat);
      in_last = (beat == 63);
      step();
      if (c % 2 == 0) begin
        eq.push_back('{AW'(beat), DW'(200 + beat)});
        beat++;
      end
    end
    idle_inputs();
    step();
    step();
    check("toggle_is_idle", 64'(is_idle), 64'd1);
    check("toggle_err", 64'(line_error), 64'd0);
    compare_writes("toggle");

    // Short line: last on beat 9.
    wq.delete(); eq.delete();
    start_line(5'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = DW'(48'h100 + i); in_last = (i == 9);
      eq.push_back('{AW'(7'h40 + i), DW'(48'h100 + i)});
      step();
    end
    idle_inputs();
    for (int k = 0; k < 100; k++) begin
      if (is_idle) break;
      step();
    end
    check("short_idle_reached", 64'(is_idle), 64'd1);
`ifdef LOADER_PAD_EN
    check("short_we_at_idle", 64'(write_enable), 64'd1);
    check("short_last_pad_addr", 64'(write_address), 64'h7F);
    for (int j = 10; j < 64; j++) eq.push_back('{AW'(7'h40 + j), DW'(0)});
`else
    check("short_we_at_idle", 64'(write_enable), 64'd0);
`endif
    step();
    check("short_err", 64'(line_error), 64'd1);
    compare_writes("short");

    // Overlong line: 70 beats, last on beat 69.
    wq.delete(); eq.delete();
    start_line(5'd2);
    for (int i = 0; i < 70; i++) begin
      in_valid = 1'b1; in_data = DW'(48'h300 + i); in_last = (i == 69);
      if (i < 64) eq.push_back('{AW'(i), DW'(48'h300 + i)});
      step();
    end
    check("long_is_idle", 64'(is_idle), 64'd1);
    check("long_we_after_drop", 64'(write_enable), 64'd0);
    check("long_err", 64'(line_error), 64'd1);
    idle_inputs();
    step();
    compare_writes("long");

    // Reset asserted mid-line at beat 20.
    wq.delete();
    start_line(5'd5);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = DW'(48'h500 + i); in_last = 1'b0;
      step();
    end
    in_valid = 1'b0;
    step();
    check("midrst_writes_before", 64'(wq.size()), 64'd20);
    in_valid = 1'b1; in_data = DW'(48'h514);
    #2 reset = 1'b0;
    #1;
    check("midrst_we", 64'(write_enable), 64'd0);
    check("midrst_is_idle", 64'(is_idle), 64'd1);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    step();
    reset = 1'b1;
    n = wq.size();
    for (int i = 0; i < 5; i++) step();
    check("midrst_no_writes_after", 64'(wq.size()), 64'(n));
    check("midrst_still_idle", 64'(is_idle), 64'd1);

    // Second start during a load is ignored.
    wq.delete(); eq.delete();
    idle_inputs();
    start_line(5'd5);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = DW'(48'h600 + i); in_last = 1'b0;
      start = (i == 3); y = (i == 3) ? 5'd2 : 5'd0;
      eq.push_back('{AW'(7'h40 + i), DW'(48'h600 + i)});
      step();
    end
    idle_inputs();
    step();
    check("restart_not_idle", 64'(is_idle), 64'd0);
    compare_writes("restart");
    apply_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
